// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - Default bus widths (execute->memory, memory->write-back, memory->decode).
//   - Bit offsets of the named fields inside the execute->memory bus.
//     Bits above OFF_EX are opaque payload that passes through unchanged.
//   - Load-type encodings carried in the mem_type field.
package mem_stage_pkg;

    localparam int EX_MEM_W = 240;
    localparam int MEM_WB_W = 240;
    localparam int MEM_ID_W = 53;

    // Field offsets (LSB position) inside ex_mem_bus / bus_r.
    localparam int OFF_CSR_NUM      = 0;   // [13:0]
    localparam int OFF_CSR_RE       = 14;
    localparam int OFF_RESULT       = 15;  // [31:0]
    localparam int OFF_DEST         = 47;  // [4:0]
    localparam int OFF_ADDR_LOW2    = 52;  // [1:0]
    localparam int OFF_MEM_TYPE     = 54;  // [2:0]
    localparam int OFF_RES_FROM_MEM = 57;
    localparam int OFF_GR_WE        = 58;
    localparam int OFF_ERTN         = 59;
    localparam int OFF_EX           = 60;

    // mem_type encodings: bit 2 selects zero extension, bits 1:0 the size.
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: purely combinational load-data alignment and extension.
//   rd        in  32  raw word read from the data SRAM (or its held copy)
//   addr_low2 in  2   byte offset of the access within the word
//   mem_type  in  3   load type (LD_B/LD_H/LD_W/LD_BU/LD_HU)
//   load_data out 32  aligned, sign/zero-extended load result
// The byte/half selects are equivalent to taking the low bits of
// rd >> (8*addr_low2); a halfword at offset 3 sees zero in its top byte.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  addr_low2,
    input  logic [2:0]  mem_type,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd[7:0];
        half_sel = rd[15:0];
        case (addr_low2)
            2'd0: begin byte_sel = rd[7:0];   half_sel = rd[15:0];           end
            2'd1: begin byte_sel = rd[15:8];  half_sel = rd[23:8];           end
            2'd2: begin byte_sel = rd[23:16]; half_sel = rd[31:16];          end
            default: begin byte_sel = rd[31:24]; half_sel = {8'h00, rd[31:24]}; end
        endcase
    end

    always_comb begin
        load_data = rd;
        case (mem_type)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'h0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'h0, half_sel};
            LD_W:    load_data = rd;
            default: load_data = rd;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage in-order pipeline.
//   clk, reset        clock; asynchronous active-high reset
//   ex_mem_valid/bus  instruction offered by execute
//   mem_allowin       this stage accepts an instruction this cycle
//   data_sram_rdata   synchronous SRAM read data, valid the cycle after request
//   mem_wb_valid/bus  instruction offered to write-back (result -> final_result)
//   wb_allowin        write-back accepts
//   wb_ex, ertn_flush flush requests from write-back
//   mem_ex            valid instruction here carries ex or ertn
//   mem_id_bus        forwarding to decode {bypass, dest, final_result, csr_re, csr_num}
//
// Handshake: a transfer happens on a clock edge where the upstream valid
// and this stage's allowin are both high (ex_mem_valid & mem_allowin), and
// likewise downstream (mem_wb_valid & wb_allowin). Valid never depends on
// the receiver's allowin; this stage never stalls by itself, so
// mem_allowin = ~mem_valid | wb_allowin.
module mem_stage #(
    parameter int EX_MEM_W = mem_stage_pkg::EX_MEM_W,
    parameter int MEM_WB_W = mem_stage_pkg::MEM_WB_W,
    parameter int MEM_ID_W = mem_stage_pkg::MEM_ID_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_mem_valid,
    output logic                mem_allowin,
    input  logic [EX_MEM_W-1:0] ex_mem_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic                mem_wb_valid,
    input  logic                wb_allowin,
    output logic [MEM_WB_W-1:0] mem_wb_bus,
    input  logic                wb_ex,
    input  logic                ertn_flush,
    output logic                mem_ex,
    output logic [MEM_ID_W-1:0] mem_id_bus
);

    import mem_stage_pkg::*;

    logic                mem_valid;
    logic [EX_MEM_W-1:0] bus_r;
    logic [31:0]         rdata_hold;
    logic                hold_vld;
    logic                first_cyc;

    logic        flush;
    logic        entry;
    logic        capture;
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  mem_type;
    logic [1:0]  addr_low2;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        ertn;
    logic        ex;
    logic [31:0] rd;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        bypass;
    logic [EX_MEM_W-1:0] bus_out;

    assign gr_we        = bus_r[OFF_GR_WE];
    assign res_from_mem = bus_r[OFF_RES_FROM_MEM];
    assign mem_type     = bus_r[OFF_MEM_TYPE +: 3];
    assign addr_low2    = bus_r[OFF_ADDR_LOW2 +: 2];
    assign dest         = bus_r[OFF_DEST +: 5];
    assign result       = bus_r[OFF_RESULT +: 32];
    assign csr_re       = bus_r[OFF_CSR_RE];
    assign csr_num      = bus_r[OFF_CSR_NUM +: 14];
    assign ertn         = bus_r[OFF_ERTN];
    assign ex           = bus_r[OFF_EX];

    assign flush        = wb_ex | ertn_flush;
    assign mem_allowin  = ~mem_valid | wb_allowin;
    assign mem_wb_valid = mem_valid;
    assign entry        = ex_mem_valid & mem_allowin;

    // The SRAM only presents the read word in the entry cycle; if write-back
    // is not taking us then, keep a copy for the remaining stall cycles.
    assign capture = first_cyc & mem_valid & res_from_mem & ~wb_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            first_cyc <= 1'b0;
            hold_vld  <= 1'b0;
        end else if (flush) begin
            mem_valid <= 1'b0;
            first_cyc <= 1'b0;
            hold_vld  <= 1'b0;
        end else begin
            if (mem_allowin) begin
                mem_valid <= ex_mem_valid;
            end
            first_cyc <= entry;
            // mem_allowin covers both exit and an empty stage, so every
            // new entry starts without a held word.
            if (mem_allowin) begin
                hold_vld <= 1'b0;
            end else if (capture) begin
                hold_vld <= 1'b1;
            end
        end
    end

    // Payload and held data carry no reset; they are qualified by the
    // valid bits above.
    always_ff @(posedge clk) begin
        if (entry) begin
            bus_r <= ex_mem_bus;
        end
        if (capture) begin
            rdata_hold <= data_sram_rdata;
        end
    end

    assign rd = hold_vld ? rdata_hold : data_sram_rdata;

    load_align u_load_align (
        .rd        (rd),
        .addr_low2 (addr_low2),
        .mem_type  (mem_type),
        .load_data (load_data)
    );

    assign final_result = res_from_mem ? load_data : result;
    assign bypass       = mem_valid & gr_we & ~ex;
    assign mem_ex       = mem_valid & (ex | ertn);

    always_comb begin
        bus_out = bus_r;
        bus_out[OFF_RESULT +: 32] = final_result;
    end

    assign mem_wb_bus = MEM_WB_W'(bus_out);
    assign mem_id_bus = MEM_ID_W'({bypass, dest, final_result, csr_re, csr_num});

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                clk;
    logic                reset;
    logic                ex_mem_valid;
    logic                mem_allowin;
    logic [EX_MEM_W-1:0] ex_mem_bus;
    logic [31:0]         data_sram_rdata;
    logic                mem_wb_valid;
    logic                wb_allowin;
    logic [MEM_WB_W-1:0] mem_wb_bus;
    logic                wb_ex;
    logic                ertn_flush;
    logic                mem_ex;
    logic [MEM_ID_W-1:0] mem_id_bus;

    int n_cmp;
    int n_fail;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_valid    (ex_mem_valid),
        .mem_allowin     (mem_allowin),
        .ex_mem_bus      (ex_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .mem_wb_bus      (mem_wb_bus),
        .wb_ex           (wb_ex),
        .ertn_flush      (ertn_flush),
        .mem_ex          (mem_ex),
        .mem_id_bus      (mem_id_bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an execute payload; passthrough bits carry a fixed pattern so
    // any corruption of untouched fields is visible on mem_wb_bus.
    function automatic logic [EX_MEM_W-1:0] mk_bus(
        input logic gr_we_i, input logic rfm_i, input logic [2:0] mt_i,
        input logic [1:0] al_i, input logic [4:0] dest_i, input logic [31:0] res_i,
        input logic csr_re_i, input logic [13:0] csr_num_i,
        input logic ertn_i, input logic ex_i);
        logic [EX_MEM_W-1:0] b;
        b = {8{30'h2AAA_5555}};
        b[OFF_GR_WE]             = gr_we_i;
        b[OFF_RES_FROM_MEM]      = rfm_i;
        b[OFF_MEM_TYPE +: 3]     = mt_i;
        b[OFF_ADDR_LOW2 +: 2]    = al_i;
        b[OFF_DEST +: 5]         = dest_i;
        b[OFF_RESULT +: 32]      = res_i;
        b[OFF_CSR_RE]            = csr_re_i;
        b[OFF_CSR_NUM +: 14]     = csr_num_i;
        b[OFF_ERTN]              = ertn_i;
        b[OFF_EX]                = ex_i;
        return b;
    endfunction

    // Driver: offer one instruction, return #1 after the accepting edge
    // with ex_mem_valid dropped.
    task automatic issue(input logic [EX_MEM_W-1:0] b);
        ex_mem_valid = 1'b1;
        ex_mem_bus   = b;
        @(posedge clk);
        #1;
        ex_mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", mem_wb_valid); end
        n_cmp++; if (mem_ex !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ex got %b exp 0", mem_ex); end
        n_cmp++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_allowin got %b exp 1", mem_allowin); end
        n_cmp++; if (mem_id_bus[52] !== 1'b0) begin n_fail++; $display("FAIL rst_bypass got %b exp 0", mem_id_bus[52]); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ld_byte();
        logic [EX_MEM_W-1:0] exp_bus;
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b1, LD_B, 2'd3, 5'd5, 32'h0000_1003, 1'b0, 14'h0, 1'b0, 1'b0));
        data_sram_rdata = 32'h80FF_1234;
        #1;
        exp_bus = mk_bus(1'b1, 1'b1, LD_B, 2'd3, 5'd5, 32'hFFFF_FF80, 1'b0, 14'h0, 1'b0, 1'b0);
        n_cmp++; if (mem_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid got %b exp 1", mem_wb_valid); end
        n_cmp++; if (mem_wb_bus !== exp_bus) begin n_fail++; $display("FAIL ldb_bus got %h exp %h", mem_wb_bus, exp_bus); end
        n_cmp++; if (mem_id_bus !== {1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 14'h0}) begin n_fail++; $display("FAIL ldb_id got %h", mem_id_bus); end
        issue(mk_bus(1'b1, 1'b1, LD_BU, 2'd3, 5'd6, 32'h0000_1003, 1'b0, 14'h0, 1'b0, 1'b0));
        #1;
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'h0000_0080) begin n_fail++; $display("FAIL ldbu_res got %h exp 00000080", mem_wb_bus[OFF_RESULT +: 32]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold();
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b1, LD_H, 2'd2, 5'd7, 32'h0000_2002, 1'b0, 14'h0, 1'b0, 1'b0));
        wb_allowin = 1'b0;
        data_sram_rdata = 32'h8001_0000;
        #1;
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'hFFFF_8001) begin n_fail++; $display("FAIL ldh_live got %h exp ffff8001", mem_wb_bus[OFF_RESULT +: 32]); end
        n_cmp++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL ldh_allowin got %b exp 0", mem_allowin); end
        @(posedge clk);
        #1;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (dut.hold_vld !== 1'b1) begin n_fail++; $display("FAIL ldh_hold got %b exp 1", dut.hold_vld); end
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'hFFFF_8001) begin n_fail++; $display("FAIL ldh_stall got %h exp ffff8001", mem_wb_bus[OFF_RESULT +: 32]); end
        repeat (2) @(posedge clk);
        #1;
        wb_allowin = 1'b1;
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ldh_rel_valid got %b exp 1", mem_wb_valid); end
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'hFFFF_8001) begin n_fail++; $display("FAIL ldh_release got %h exp ffff8001", mem_wb_bus[OFF_RESULT +: 32]); end
        @(posedge clk);
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ldh_exit_valid got %b exp 0", mem_wb_valid); end
        n_cmp++; if (dut.hold_vld !== 1'b0) begin n_fail++; $display("FAIL ldh_exit_hold got %b exp 0", dut.hold_vld); end
    endtask

    task automatic test_back_to_back();
        wb_allowin   = 1'b1;
        ex_mem_valid = 1'b1;
        ex_mem_bus   = mk_bus(1'b1, 1'b1, LD_W, 2'd0, 5'd8, 32'h0000_3000, 1'b0, 14'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        ex_mem_bus = mk_bus(1'b1, 1'b1, LD_W, 2'd0, 5'd9, 32'h0000_3004, 1'b0, 14'h0, 1'b0, 1'b0);
        data_sram_rdata = 32'h1111_1111;
        #1;
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_first got %h exp 11111111", mem_wb_bus[OFF_RESULT +: 32]); end
        n_cmp++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin got %b exp 1", mem_allowin); end
        @(posedge clk);
        #1;
        ex_mem_valid = 1'b0;
        data_sram_rdata = 32'h2222_2222;
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", mem_wb_valid); end
        n_cmp++; if (mem_id_bus !== {1'b1, 5'd9, 32'h2222_2222, 1'b0, 14'h0}) begin n_fail++; $display("FAIL b2b_second got %h", mem_id_bus); end
        n_cmp++; if (dut.hold_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got %b exp 0", dut.hold_vld); end
        @(posedge clk);
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", mem_wb_valid); end
    endtask

    task automatic test_flush();
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b1, LD_W, 2'd0, 5'd10, 32'h0000_4000, 1'b0, 14'h0, 1'b0, 1'b0));
        // Stalled valid load, a new instruction waiting, and wb_ex.
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'h5555_AAAA;
        ex_mem_valid    = 1'b1;
        ex_mem_bus      = mk_bus(1'b1, 1'b0, LD_W, 2'd0, 5'd11, 32'h1, 1'b0, 14'h0, 1'b0, 1'b0);
        wb_ex           = 1'b1;
        @(posedge clk);
        #1;
        wb_ex = 1'b0;
        ex_mem_valid = 1'b0;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL wbex_valid got %b exp 0", mem_wb_valid); end
        n_cmp++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL wbex_allowin got %b exp 1", mem_allowin); end
        n_cmp++; if (dut.hold_vld !== 1'b0) begin n_fail++; $display("FAIL wbex_hold got %b exp 0", dut.hold_vld); end
        // Flush coinciding with an acceptable entry: flush wins.
        wb_allowin   = 1'b1;
        ertn_flush   = 1'b1;
        ex_mem_valid = 1'b1;
        @(posedge clk);
        #1;
        ertn_flush   = 1'b0;
        ex_mem_valid = 1'b0;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ertnf_valid got %b exp 0", mem_wb_valid); end
    endtask

    task automatic test_exceptions();
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b0, LD_W, 2'd0, 5'd12, 32'h0000_00AA, 1'b0, 14'h0, 1'b0, 1'b1));
        n_cmp++; if (mem_ex !== 1'b1) begin n_fail++; $display("FAIL ex_mem_ex got %b exp 1", mem_ex); end
        n_cmp++; if (mem_id_bus[52] !== 1'b0) begin n_fail++; $display("FAIL ex_bypass got %b exp 0", mem_id_bus[52]); end
        issue(mk_bus(1'b1, 1'b0, LD_W, 2'd0, 5'd13, 32'h0000_ABCD, 1'b1, 14'h0123, 1'b1, 1'b0));
        n_cmp++; if (mem_ex !== 1'b1) begin n_fail++; $display("FAIL ertn_mem_ex got %b exp 1", mem_ex); end
        n_cmp++; if (mem_id_bus !== {1'b1, 5'd13, 32'h0000_ABCD, 1'b1, 14'h0123}) begin n_fail++; $display("FAIL ertn_id got %h", mem_id_bus); end
        @(posedge clk);
        #1;
        n_cmp++; if (mem_ex !== 1'b0) begin n_fail++; $display("FAIL ex_drain got %b exp 0", mem_ex); end
    endtask

    task automatic test_reset_mid_stall();
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b1, LD_W, 2'd0, 5'd14, 32'h0000_5000, 1'b0, 14'h0, 1'b0, 1'b1));
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'h3333_3333;
        n_cmp++; if (mem_ex !== 1'b1) begin n_fail++; $display("FAIL rs_pre_ex got %b exp 1", mem_ex); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b exp 0", mem_wb_valid); end
        n_cmp++; if (mem_ex !== 1'b0) begin n_fail++; $display("FAIL rs_mem_ex got %b exp 0", mem_ex); end
        n_cmp++; if (dut.hold_vld !== 1'b0) begin n_fail++; $display("FAIL rs_hold got %b exp 0", dut.hold_vld); end
        #2;
        reset      = 1'b0;
        wb_allowin = 1'b1;
        issue(mk_bus(1'b1, 1'b1, LD_W, 2'd0, 5'd15, 32'h0000_6000, 1'b0, 14'h0, 1'b0, 1'b0));
        data_sram_rdata = 32'h4444_4444;
        #1;
        n_cmp++; if (mem_wb_bus[OFF_RESULT +: 32] !== 32'h4444_4444) begin n_fail++; $display("FAIL rs_live got %h exp 44444444", mem_wb_bus[OFF_RESULT +: 32]); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        reset           = 1'b1;
        ex_mem_valid    = 1'b0;
        ex_mem_bus      = '0;
        data_sram_rdata = '0;
        wb_allowin      = 1'b1;
        wb_ex           = 1'b0;
        ertn_flush      = 1'b0;
        test_reset();
        test_ld_byte();
        test_hold();
        test_back_to_back();
        test_flush();
        test_exceptions();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline. It sits directly downstream of the execute stage and upstream of write-back. It latches the execute-to-memory bus under a valid/allowin handshake and captures the synchronous data-SRAM read data, including across write-back back-pressure. It aligns and extends load data, forwards results to decode, signals pending exceptions back to execute, and drops its content on a write-back exception or ertn flush.

## Interface
Parameters:
- EX_MEM_W, 240, width of the incoming execute-to-memory bus.
- MEM_WB_W, 240, width of the outgoing memory-to-write-back bus.
- MEM_ID_W, 53, width of the forwarding bus to decode.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ex_mem_valid  in  1  execute stage offers an instruction.
- mem_allowin  out  1  this stage accepts an instruction this cycle.
- ex_mem_bus  in  EX_MEM_W  execute payload.
  - Named fields: gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0], dest[4:0], result[31:0], csr_re, csr_num[13:0], ertn, ex.
  - All other fields pass through untouched.
- data_sram_rdata  in  32  synchronous SRAM read data; valid in the first cycle after the request.
- mem_wb_valid  out  1  offer to write-back.
- wb_allowin  in  1  write-back accepts.
- mem_wb_bus  out  MEM_WB_W  equals the latched bus, with result replaced by final_result.
- wb_ex  in  1  exception taken in write-back; flush.
- ertn_flush  in  1  ertn retired; flush.
- mem_ex  out  1  valid MEM instruction carries ex or ertn; execute suppresses SRAM access.
- mem_id_bus  out  MEM_ID_W  {bypass, dest, final_result, csr_re, csr_num}.

## Operation
- Registers:
  - mem_valid
  - bus_r (EX_MEM_W)
  - rdata_hold (32)
  - hold_vld
  - first_cyc (1 in the first cycle an instruction occupies MEM)
- Handshake:
  - mem_ready_go = 1.
  - mem_wb_valid = mem_valid.
  - mem_allowin = ~mem_valid | wb_allowin.
- mem_valid update priority:
  - reset: mem_valid 0.
  - else wb_ex | ertn_flush: mem_valid 0.
  - else mem_allowin: mem_valid <= ex_mem_valid.
- bus_r loads when ex_mem_valid & mem_allowin. It is not reset.
- Read-data capture:
  - Effective data: rd = hold_vld ? rdata_hold : data_sram_rdata.
  - Capture condition: first_cyc & mem_valid & res_from_mem & ~wb_allowin.
  - On capture: rdata_hold <= data_sram_rdata and hold_vld <= 1.
  - hold_vld clears on stage exit (mem_valid & wb_allowin), on flush, and on reset.
  - A new entry always starts with hold_vld = 0.
- Load alignment:
  - sh = rd >> (8*addr_low2).
  - mem_type 000 ld.b: sign-extend sh[7:0].
  - mem_type 100 ld.bu: zero-extend sh[7:0].
  - mem_type 001 ld.h: sign-extend sh[15:0].
  - mem_type 101 ld.hu: zero-extend sh[15:0].
  - mem_type 010 ld.w: rd.
  - Other encodings: rd.
- final_result = res_from_mem ? load_data : result.
- bypass = mem_valid & gr_we & ~ex.
- mem_ex = mem_valid & (ex | ertn).
- An instruction with ex=1 never uses SRAM data. Its final_result is don't-care.

## Timing
- Reset values:
  - mem_valid, hold_vld, first_cyc = 0.
  - Hence mem_wb_valid, mem_ex and bypass = 0, and mem_allowin = 1.
- Latency: one cycle from EX acceptance to mem_wb_valid. No stall is generated internally.
- Read data is consumed combinationally in the entry cycle. Under back-pressure it comes from rdata_hold in all later cycles.
- Simultaneous flush and ex_mem_valid: flush wins. The stage is empty next cycle.
- Simultaneous exit and entry: the new entry loads, first_cyc = 1, and hold_vld = 0.
- Reset asserted mid-stall: hold contents are discarded immediately (asynchronous).
- Forwarding outputs are combinational from registers. There is no path from ex_mem_bus to outputs.

## Structure
- The shared package holds:
  - EX_MEM_W, MEM_WB_W and MEM_ID_W.
  - Bus field offsets.
  - mem_type encodings (LD_B, LD_H, LD_W, LD_BU, LD_HU).
- Single sub-module load_align: inputs rd, addr_low2, mem_type; output load_data. It is purely combinational.

## Test plan
- ld.b, addr_low2=3, rdata 0x80FF_1234, wb_allowin=1 -> mem_wb_bus result 0xFFFF_FF80 one cycle after acceptance; ld.bu -> 0x0000_0080.
- ld.h, addr_low2=2, rdata 0x8001_0000, wb_allowin held 0 for 3 cycles while rdata changes to 0xDEAD_BEEF -> released result 0xFFFF_8001.
- Back-to-back ld.w (0x11111111, then 0x22222222) with wb_allowin=1 -> results in consecutive cycles, hold never set.
- wb_ex pulse while MEM holds valid load and ex_mem_valid=1 -> mem_wb_valid=0 next cycle, mem_allowin=1, hold_vld=0.
- Instruction with ex=1, gr_we=1 -> mem_ex=1, bypass=0; ertn instruction -> mem_ex=1.
- Reset asserted asynchronously during a stall -> mem_wb_valid and mem_ex drop without clock edge; first post-reset load uses live rdata.
